// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory fetch port: the fetch stage issues req/addr, memory answers ready/rdata.
interface fetch_decode_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_decode_stage.sv
// Instruction fetch plus IF/ID register with stall, flush and redirect handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fault.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                        clk,
   input  logic                        rst_n,
   fetch_decode_stage_if.master        imem,
   input  logic                        i_StallF,
   input  logic                        i_FlushD,
   input  logic                        i_PCSrc,
   input  logic [31:0]                 i_PCTarget,
   output logic [31:0]                 o_InstrD,
   output logic [31:0]                 o_PCD,
   output logic [31:0]                 o_PCPlus4D,
   output logic                        o_ValidD,
   output logic [6:0]                  o_op,
   output logic [2:0]                  o_funct3,
   output logic                        o_funct7,
   output logic                        o_misalign
);

   typedef enum logic [1:0] {
      StBoot,
      StFetch,
`ifdef FETCH_ALIGN_CHECK_EN
      StHold,
      StFault
`else
      StHold
`endif
   } state_e;

   typedef enum logic [1:0] {DKeep, DBubble, DWord, DBuf} dsel_e;

   state_e      r_state, w_state_d;
   logic [31:0] r_pcf, w_pcf_d;
   logic        r_drop, w_drop_d;
   logic [31:0] r_redir_pc, w_redir_pc_d;
   logic [31:0] r_hold_instr, w_hold_instr_d;
   logic [31:0] r_hold_pc, w_hold_pc_d;
   logic [31:0] r_instr_d, r_pc_d, r_pcplus4_d;
   logic        r_valid_d;
   dsel_e       w_dsel;
   logic [31:0] w_target;

`ifdef FETCH_ALIGN_CHECK_EN
   logic r_misalign;
   logic w_redir_misal;
   assign w_target      = i_PCTarget;
   assign w_redir_misal = i_PCSrc && (i_PCTarget[1:0] != 2'b00);
   assign o_misalign    = r_misalign;
`else
   assign w_target   = i_PCTarget & 32'hFFFF_FFFC;
   assign o_misalign = 1'b0;
`endif

   assign imem.imem_req  = (r_state == StFetch);
   assign imem.imem_addr = r_pcf;

   always_comb begin
      w_state_d      = r_state;
      w_pcf_d        = r_pcf;
      w_drop_d       = r_drop;
      w_redir_pc_d   = r_redir_pc;
      w_hold_instr_d = r_hold_instr;
      w_hold_pc_d    = r_hold_pc;
      w_dsel         = DKeep;
      unique case (r_state)
         StBoot: begin
            w_state_d = StFetch;
            if (!i_StallF) w_dsel = DBubble;
            if (i_PCSrc) begin
               w_pcf_d = w_target;
               w_dsel  = DBubble;
            end
         end
         StFetch: begin
            if (imem.imem_ready) begin
               if (r_drop) begin
                  // Response belongs to the squashed fetch; resume at the saved target.
                  w_pcf_d  = r_redir_pc;
                  w_drop_d = 1'b0;
                  if (!i_StallF) w_dsel = DBubble;
               end else if (!i_StallF) begin
                  w_dsel  = DWord;
                  w_pcf_d = r_pcf + 32'd4;
               end else begin
                  w_hold_instr_d = imem.imem_rdata;
                  w_hold_pc_d    = r_pcf;
                  w_pcf_d        = r_pcf + 32'd4;
                  w_state_d      = StHold;
               end
               if (i_PCSrc) begin
                  w_pcf_d   = w_target;
                  w_drop_d  = 1'b0;
                  w_state_d = StFetch;
                  w_dsel    = DBubble;
               end
            end else begin
               if (!i_StallF) w_dsel = DBubble;
               // Address must stay put until ready, so remember where to go next.
               if (i_PCSrc) begin
                  w_redir_pc_d = w_target;
                  w_drop_d     = 1'b1;
                  w_dsel       = DBubble;
               end
            end
         end
         StHold: begin
            if (!i_StallF) begin
               w_dsel    = DBuf;
               w_state_d = StFetch;
            end
            if (i_PCSrc) begin
               w_pcf_d   = w_target;
               w_state_d = StFetch;
               w_dsel    = DBubble;
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         StFault: w_dsel = DBubble;
`endif
         default: begin
            w_state_d = StBoot;
            w_dsel    = DBubble;
         end
      endcase
      if (i_FlushD) w_dsel = DBubble;
`ifdef FETCH_ALIGN_CHECK_EN
      if (w_redir_misal && (r_state != StFault)) begin
         w_state_d    = StFault;
         w_pcf_d      = r_pcf;
         w_drop_d     = 1'b0;
         w_redir_pc_d = r_redir_pc;
         w_dsel       = DBubble;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StBoot;
         r_pcf        <= RESET_PC;
         r_drop       <= 1'b0;
         r_redir_pc   <= 32'h0;
         r_hold_instr <= 32'h0;
         r_hold_pc    <= 32'h0;
      end else begin
         r_state      <= w_state_d;
         r_pcf        <= w_pcf_d;
         r_drop       <= w_drop_d;
         r_redir_pc   <= w_redir_pc_d;
         r_hold_instr <= w_hold_instr_d;
         r_hold_pc    <= w_hold_pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_d   <= NOP_INSTR;
         r_pc_d      <= 32'h0;
         r_pcplus4_d <= 32'h0;
         r_valid_d   <= 1'b0;
      end else begin
         unique case (w_dsel)
            DBubble: begin
               r_instr_d <= NOP_INSTR;
               r_valid_d <= 1'b0;
            end
            DWord: begin
               r_instr_d   <= imem.imem_rdata;
               r_pc_d      <= r_pcf;
               r_pcplus4_d <= r_pcf + 32'd4;
               r_valid_d   <= 1'b1;
            end
            DBuf: begin
               r_instr_d   <= r_hold_instr;
               r_pc_d      <= r_hold_pc;
               r_pcplus4_d <= r_hold_pc + 32'd4;
               r_valid_d   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_misalign <= 1'b0;
      else if (w_state_d == StFault) r_misalign <= 1'b1;
   end
`endif

   assign o_InstrD   = r_instr_d;
   assign o_PCD      = r_pc_d;
   assign o_PCPlus4D = r_pcplus4_d;
   assign o_ValidD   = r_valid_d;
   assign o_op       = r_instr_d[6:0];
   assign o_funct3   = r_instr_d[14:12];
   assign o_funct7   = r_instr_d[30];

endmodule
